pipeline_control_unit: RTL and testbench
========================================

PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 Parameter WIDTH, default 20, instruction width in bits.
REQ-002 Parameter OPC_W, default 5, opcode width in bits, taken from instr[WIDTH-1 -: OPC_W].
REQ-003 Parameter STAGES, default 4, stage count (fetch, decode, execute, write-back), legal range 3..8.
REQ-004 Parameter MC_CYCLES, default 3, execute-stage residency for multi-cycle opcodes, legal range 1..15.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 instr  in  WIDTH  instruction offered for issue.
REQ-008 instr_valid  in  1  instr is valid this cycle.
REQ-009 instr_ready  out  1  unit accepts instr this cycle.
REQ-010 stall  in  1  freeze the current stage.
REQ-011 div_by_zero_flag  in  1  execute-stage fault.
REQ-012 mem_violation_flag  in  1  execute-stage fault.
REQ-013 trap_clear  in  1  leave trap mode.
REQ-014 stage_en  out  STAGES  one-hot stage enable, bit 0 = fetch.
REQ-015 retire  out  1  single-cycle pulse when an instruction completes its last stage.
REQ-016 trap_mode_flag  out  1  unit is in trap.
REQ-017 trap_cause  out  2  latched trap cause: 0 none, 1 trap opcode, 2 div-by-zero, 3 memory violation.

Function
REQ-018 States SHALL be IDLE, RUN, EXEC_WAIT and TRAP; RUN carries a stage index 0..STAGES-1.
REQ-019 Handshake: an instruction SHALL transfer only on the rising edge where instr_valid and instr_ready are both 1; the unit SHALL latch instr at that edge.
REQ-020 instr_ready SHALL be 1 in IDLE, and 1 in RUN at stage STAGES-1 with stall=0; it SHALL be 0 otherwise.
REQ-021 The cycle after a transfer, stage_en SHALL equal 1 (fetch); the index SHALL advance by one per non-stalled cycle.
REQ-022 Execute index SHALL be STAGES-2; write-back index SHALL be STAGES-1.
REQ-023 Multi-cycle opcodes (OP_MUL, OP_DIV) SHALL hold stage_en at the execute bit for exactly MC_CYCLES non-stalled cycles (EXEC_WAIT, down-counter); all other opcodes hold it for 1.
REQ-024 Uninterrupted single-cycle latency: transfer at edge N; stage_en[k] high in cycle N+1+k; retire high in cycle N+STAGES together with stage_en[STAGES-1].
REQ-025 A transfer at the write-back cycle SHALL give back-to-back issue: the next cycle shows stage_en=1 with no idle bubble.
REQ-026 With stall=1, state, index, exec counter and stage_en SHALL hold, and retire SHALL be 0.
REQ-027 Opcode OP_TRAP (0) in decode SHALL enter TRAP the next cycle with cause 1; the instruction SHALL NOT reach execute, and retire SHALL NOT pulse.
REQ-028 A fault flag high in any execute cycle SHALL enter TRAP the next cycle, aborting write-back; a simultaneous div_by_zero and mem_violation SHALL latch cause 3.
REQ-029 Priority SHALL be reset > fault > stall > advance; a fault during stall SHALL still trap.
REQ-030 In TRAP: stage_en=0, instr_ready=0, trap_mode_flag=1, cause held; trap_clear=1 SHALL move to IDLE the next cycle and zero the cause.
REQ-031 trap_clear outside TRAP SHALL be ignored.

Reset
REQ-032 While reset=0 at a clock edge: state IDLE, stage_en=0, retire=0, trap_mode_flag=0, trap_cause=0, counters 0, latched instr 0.
REQ-033 Reset mid-operation SHALL discard the in-flight instruction, with no retire pulse.
REQ-034 instr_ready SHALL be 1 from the first cycle after reset is released.

Structure
REQ-035 Package cpu_ctrl_pkg SHALL hold the opcode constants (OP_TRAP=0, OP_MUL=7, OP_DIV=8), the trap-cause encodings and the state enumeration.
REQ-036 The execute-residency down-counter SHALL be one sub-module, exec_timer, with load, enable and done ports.

Verification (defaults)
REQ-037 Transfer 20'b00100110010100000010 at cycle 0 -> stage_en 0001, 0010, 0100, 1000 in cycles 1-4; retire in cycle 4.
REQ-038 Transfer opcode 8 (DIV) -> stage_en=0100 for 3 cycles, retire in cycle 6.
REQ-039 Transfer 20'b0 -> TRAP at cycle 3, trap_cause=1, no retire; trap_clear at cycle 5 -> IDLE, instr_ready=1 at cycle 6.
REQ-040 Both faults high during execute -> trap_cause=3, stage_en=0, no retire.
REQ-041 stall high for 2 cycles during decode -> retire delayed to cycle 6; a second instr_valid held high -> stage_en=0001 in cycle 7.
REQ-042 reset=0 during execute -> all outputs at reset values next cycle, no retire pulse.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: opcode constants, trap-cause
// encodings, FSM state enumeration and opcode classification helper.
package cpu_ctrl_pkg;

  localparam int unsigned OP_TRAP = 0;
  localparam int unsigned OP_MUL  = 7;
  localparam int unsigned OP_DIV  = 8;

  typedef enum logic [1:0] {
    CauseNone    = 2'd0,
    CauseTrapOp  = 2'd1,
    CauseDivZero = 2'd2,
    CauseMemViol = 2'd3
  } trap_cause_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StExecWait,
    StTrap
  } state_e;

  // Opcodes that stay in execute for more than one cycle.
  function automatic logic is_multi_cycle(input logic [31:0] opc);
    return (opc == OP_MUL) || (opc == OP_DIV);
  endfunction

endpackage

// File: rtl/exec_timer.sv
// Execute-stage residency down-counter.
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous active-low reset, clears the count
//   load     - load load_val into the counter
//   load_val - residency in cycles (1..15)
//   enable   - decrement by one (ignored while load is high)
//   done     - current cycle is the last residency cycle
module exec_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       enable,
  output logic       done
);

  logic [3:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (enable && (count_q != 4'd0)) begin
      count_q <= count_q - 4'd1;
    end
  end

  // A count of 0 is treated as done so a stray enable can never wedge the FSM.
  assign done = (count_q <= 4'd1);

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline control unit: accepts one instruction at a time over a valid/ready
// handshake, walks it through STAGES one-hot stage enables, holds multi-cycle
// opcodes in execute for MC_CYCLES cycles, and traps on the trap opcode or
// execute-stage faults.
// Ports:
//   clk, reset          - clock and synchronous active-low reset
//   instr, instr_valid  - instruction offer; instr_ready accepts it
//   stall               - freeze the current stage
//   div_by_zero_flag,
//   mem_violation_flag  - execute-stage faults
//   trap_clear          - leave trap mode
//   stage_en            - one-hot stage enable, bit 0 = fetch
//   retire              - pulse when an instruction completes write-back
//   trap_mode_flag      - unit is in trap
//   trap_cause          - latched trap cause
module pipeline_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 20,
  parameter int unsigned OPC_W     = 5,
  parameter int unsigned STAGES    = 4,
  parameter int unsigned MC_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              stall,
  input  logic              div_by_zero_flag,
  input  logic              mem_violation_flag,
  input  logic              trap_clear,
  output logic [STAGES-1:0] stage_en,
  output logic              retire,
  output logic              trap_mode_flag,
  output logic [1:0]        trap_cause
);

  localparam logic [2:0] DecIdx     = 3'd1;
  localparam logic [2:0] PreExecIdx = 3'(STAGES - 3);
  localparam logic [2:0] ExecIdx    = 3'(STAGES - 2);
  localparam logic [2:0] WbIdx      = 3'(STAGES - 1);
  localparam logic [STAGES-1:0] FetchEn = STAGES'(1);

  state_e            state_q;
  logic [2:0]        idx_q;
  logic [WIDTH-1:0]  instr_q;
  logic [STAGES-1:0] stage_en_q;
  logic              trap_q;
  trap_cause_e       cause_q;

  logic [31:0] opc32;
  logic        in_exec, fault, at_wb, multi;
  logic        timer_load, timer_en, timer_done;
  logic        unused_instr_bits;

  assign opc32   = 32'(instr_q[WIDTH-1 -: OPC_W]);
  assign multi   = is_multi_cycle(opc32);
  assign fault   = div_by_zero_flag | mem_violation_flag;
  assign in_exec = ((state_q == StRun) && (idx_q == ExecIdx)) || (state_q == StExecWait);
  assign at_wb   = (state_q == StRun) && (idx_q == WbIdx);

  // Only the opcode field steers control; the operand bits are carried but unused.
  assign unused_instr_bits = ^instr_q[WIDTH-OPC_W-1:0];

  assign timer_load = (state_q == StRun) && (idx_q == PreExecIdx) && !stall && multi;
  assign timer_en   = (state_q == StExecWait) && !stall && !fault;

  exec_timer u_exec_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (4'(MC_CYCLES)),
    .enable   (timer_en),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      instr_q    <= '0;
      stage_en_q <= '0;
      trap_q     <= 1'b0;
      cause_q    <= CauseNone;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (instr_valid) begin
            instr_q    <= instr;
            state_q    <= StRun;
            idx_q      <= '0;
            stage_en_q <= FetchEn;
          end
        end
        StRun, StExecWait: begin
          if (in_exec && fault) begin
            // Faults override stall; mem violation wins when both are raised.
            state_q    <= StTrap;
            stage_en_q <= '0;
            trap_q     <= 1'b1;
            cause_q    <= mem_violation_flag ? CauseMemViol : CauseDivZero;
          end else if (stall) begin
            // Hold everything.
          end else if (state_q == StExecWait) begin
            if (timer_done) begin
              state_q    <= StRun;
              idx_q      <= WbIdx;
              stage_en_q <= stage_en_q << 1;
            end
          end else if (idx_q == WbIdx) begin
            // Back-to-back issue straight out of write-back.
            if (instr_valid) begin
              instr_q    <= instr;
              idx_q      <= '0;
              stage_en_q <= FetchEn;
            end else begin
              state_q    <= StIdle;
              idx_q      <= '0;
              stage_en_q <= '0;
            end
          end else if ((idx_q == DecIdx) && (opc32 == OP_TRAP)) begin
            state_q    <= StTrap;
            stage_en_q <= '0;
            trap_q     <= 1'b1;
            cause_q    <= CauseTrapOp;
          end else if (timer_load) begin
            state_q    <= StExecWait;
            idx_q      <= ExecIdx;
            stage_en_q <= stage_en_q << 1;
          end else begin
            idx_q      <= idx_q + 3'd1;
            stage_en_q <= stage_en_q << 1;
          end
        end
        StTrap: begin
          if (trap_clear) begin
            state_q <= StIdle;
            idx_q   <= '0;
            trap_q  <= 1'b0;
            cause_q <= CauseNone;
          end
        end
      endcase
    end
  end

  assign stage_en       = stage_en_q;
  assign trap_mode_flag = trap_q;
  assign trap_cause     = cause_q;
  // Retire and ready follow the live stall so a frozen write-back neither retires nor accepts.
  assign retire         = reset && at_wb && !stall;
  assign instr_ready    = (state_q == StIdle) || (at_wb && !stall);

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit: stimulus pushes per-cycle
// expected outputs, an independent monitor pops and compares on the falling edge.
module tb_pipeline_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] instr;
  logic        instr_valid, instr_ready, stall;
  logic        div_by_zero_flag, mem_violation_flag, trap_clear;
  logic [3:0]  stage_en;
  logic        retire, trap_mode_flag;
  logic [1:0]  trap_cause;

  pipeline_control_unit #(
    .WIDTH     (20),
    .OPC_W     (5),
    .STAGES    (4),
    .MC_CYCLES (3)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .instr              (instr),
    .instr_valid        (instr_valid),
    .instr_ready        (instr_ready),
    .stall              (stall),
    .div_by_zero_flag   (div_by_zero_flag),
    .mem_violation_flag (mem_violation_flag),
    .trap_clear         (trap_clear),
    .stage_en           (stage_en),
    .retire             (retire),
    .trap_mode_flag     (trap_mode_flag),
    .trap_cause         (trap_cause)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [3:0] se;
    logic       ret;
    logic       rdy;
    logic       tm;
    logic [1:0] cause;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   checks = 0;
  int   errors = 0;
  int   base   = 0;

  task automatic ex(input int rel, input logic [3:0] se, input logic ret, input logic rdy,
                    input logic tm, input logic [1:0] cause, input string nm);
    exp_t e;
    e.c = base + rel; e.se = se; e.ret = ret; e.rdy = rdy; e.tm = tm; e.cause = cause; e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation due this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
      e_mon = exp_q.pop_front();
      checks++;
      if (e_mon.c != cyc || stage_en !== e_mon.se || retire !== e_mon.ret ||
          instr_ready !== e_mon.rdy || trap_mode_flag !== e_mon.tm ||
          trap_cause !== e_mon.cause) begin
        errors++;
        $display("FAIL %s cyc=%0d got se=%b ret=%b rdy=%b trap=%b cause=%0d want se=%b ret=%b rdy=%b trap=%b cause=%0d",
                 e_mon.nm, cyc, stage_en, retire, instr_ready, trap_mode_flag, trap_cause,
                 e_mon.se, e_mon.ret, e_mon.rdy, e_mon.tm, e_mon.cause);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got no finish, want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; instr = '0; instr_valid = 0; stall = 0;
    div_by_zero_flag = 0; mem_violation_flag = 0; trap_clear = 0;
    repeat (2) step();
    base = cyc;
    ex(0, 4'b0000, 0, 1, 0, 0, "reset_vals");
    ex(1, 4'b0000, 0, 1, 0, 0, "ready_after_reset");
    reset = 1'b1;
    step(); step();

    // Plain instruction, with an ignored trap_clear while running.
    base = cyc;
    instr = 20'b00100110010100000010; instr_valid = 1;
    ex(0, 4'b0000, 0, 1, 0, 0, "t1_idle");
    ex(1, 4'b0001, 0, 0, 0, 0, "t1_fetch");
    ex(2, 4'b0010, 0, 0, 0, 0, "t1_decode");
    ex(3, 4'b0100, 0, 0, 0, 0, "t1_exec");
    ex(4, 4'b1000, 1, 1, 0, 0, "t1_wb_retire");
    ex(5, 4'b0000, 0, 1, 0, 0, "t1_back_idle");
    step(); instr_valid = 0;
    step(); trap_clear = 1;
    step(); trap_clear = 0;
    repeat (3) step();

    // DIV holds execute for 3 cycles.
    base = cyc;
    instr = {5'd8, 15'h1234}; instr_valid = 1;
    ex(0, 4'b0000, 0, 1, 0, 0, "t2_idle");
    ex(1, 4'b0001, 0, 0, 0, 0, "t2_fetch");
    ex(2, 4'b0010, 0, 0, 0, 0, "t2_decode");
    ex(3, 4'b0100, 0, 0, 0, 0, "t2_exec1");
    ex(4, 4'b0100, 0, 0, 0, 0, "t2_exec2");
    ex(5, 4'b0100, 0, 0, 0, 0, "t2_exec3");
    ex(6, 4'b1000, 1, 1, 0, 0, "t2_wb_retire");
    ex(7, 4'b0000, 0, 1, 0, 0, "t2_back_idle");
    step(); instr_valid = 0;
    repeat (7) step();

    // Trap opcode.
    base = cyc;
    instr = 20'h00abc; instr_valid = 1;
    ex(0, 4'b0000, 0, 1, 0, 0, "t3_idle");
    ex(1, 4'b0001, 0, 0, 0, 0, "t3_fetch");
    ex(2, 4'b0010, 0, 0, 0, 0, "t3_decode");
    ex(3, 4'b0000, 0, 0, 1, 1, "t3_trap");
    ex(4, 4'b0000, 0, 0, 1, 1, "t3_trap_hold");
    ex(5, 4'b0000, 0, 0, 1, 1, "t3_trap_clear_cyc");
    ex(6, 4'b0000, 0, 1, 0, 0, "t3_cleared");
    step(); instr_valid = 0;
    repeat (4) step();
    trap_clear = 1;
    step(); trap_clear = 0;
    step();

    // Both faults in execute.
    base = cyc;
    instr = {5'd4, 15'd5}; instr_valid = 1;
    ex(0, 4'b0000, 0, 1, 0, 0, "t4_idle");
    ex(1, 4'b0001, 0, 0, 0, 0, "t4_fetch");
    ex(2, 4'b0010, 0, 0, 0, 0, "t4_decode");
    ex(3, 4'b0100, 0, 0, 0, 0, "t4_exec");
    ex(4, 4'b0000, 0, 0, 1, 3, "t4_trap_both");
    ex(5, 4'b0000, 0, 0, 1, 3, "t4_trap_hold");
    ex(6, 4'b0000, 0, 1, 0, 0, "t4_cleared");
    step(); instr_valid = 0;
    step();
    step(); div_by_zero_flag = 1; mem_violation_flag = 1;
    step(); div_by_zero_flag = 0; mem_violation_flag = 0;
    step(); trap_clear = 1;
    step(); trap_clear = 0;
    step();

    // MUL: div-by-zero during a stalled execute-wait cycle still traps.
    base = cyc;
    instr = {5'd7, 15'd3}; instr_valid = 1;
    ex(0, 4'b0000, 0, 1, 0, 0, "t5_idle");
    ex(1, 4'b0001, 0, 0, 0, 0, "t5_fetch");
    ex(2, 4'b0010, 0, 0, 0, 0, "t5_decode");
    ex(3, 4'b0100, 0, 0, 0, 0, "t5_exec1");
    ex(4, 4'b0100, 0, 0, 0, 0, "t5_exec2_stall");
    ex(5, 4'b0000, 0, 0, 1, 2, "t5_trap_div");
    ex(6, 4'b0000, 0, 0, 1, 2, "t5_trap_hold");
    ex(7, 4'b0000, 0, 1, 0, 0, "t5_cleared");
    step(); instr_valid = 0;
    step(); step();
    step(); stall = 1; div_by_zero_flag = 1;
    step(); stall = 0; div_by_zero_flag = 0;
    step(); trap_clear = 1;
    step(); trap_clear = 0;
    step();

    // Decode stall, then back-to-back issue from write-back.
    base = cyc;
    instr = {5'd4, 15'd1}; instr_valid = 1;
    ex(0,  4'b0000, 0, 1, 0, 0, "t6_idle");
    ex(1,  4'b0001, 0, 0, 0, 0, "t6_fetch");
    ex(2,  4'b0010, 0, 0, 0, 0, "t6_decode_stall1");
    ex(3,  4'b0010, 0, 0, 0, 0, "t6_decode_stall2");
    ex(4,  4'b0010, 0, 0, 0, 0, "t6_decode");
    ex(5,  4'b0100, 0, 0, 0, 0, "t6_exec");
    ex(6,  4'b1000, 1, 1, 0, 0, "t6_wb_retire");
    ex(7,  4'b0001, 0, 0, 0, 0, "t6_b2b_fetch");
    ex(8,  4'b0010, 0, 0, 0, 0, "t6_b_decode");
    ex(9,  4'b0100, 0, 0, 0, 0, "t6_b_exec");
    ex(10, 4'b1000, 1, 1, 0, 0, "t6_b_retire");
    ex(11, 4'b0000, 0, 1, 0, 0, "t6_back_idle");
    step(); instr = {5'd3, 15'd9};
    step(); stall = 1;
    step();
    step(); stall = 0;
    step(); step();
    step(); instr_valid = 0;
    repeat (5) step();

    // Stall in write-back suppresses retire and ready.
    base = cyc;
    instr = {5'd4, 15'd2}; instr_valid = 1;
    ex(0, 4'b0000, 0, 1, 0, 0, "t7_idle");
    ex(1, 4'b0001, 0, 0, 0, 0, "t7_fetch");
    ex(2, 4'b0010, 0, 0, 0, 0, "t7_decode");
    ex(3, 4'b0100, 0, 0, 0, 0, "t7_exec");
    ex(4, 4'b1000, 0, 0, 0, 0, "t7_wb_stalled");
    ex(5, 4'b1000, 1, 1, 0, 0, "t7_wb_retire");
    ex(6, 4'b0000, 0, 1, 0, 0, "t7_back_idle");
    step(); instr_valid = 0;
    step(); step();
    step(); stall = 1;
    step(); stall = 0;
    step(); step();

    // Reset during execute discards the instruction.
    base = cyc;
    instr = {5'd4, 15'd7}; instr_valid = 1;
    ex(0, 4'b0000, 0, 1, 0, 0, "t8_idle");
    ex(1, 4'b0001, 0, 0, 0, 0, "t8_fetch");
    ex(2, 4'b0010, 0, 0, 0, 0, "t8_decode");
    ex(3, 4'b0100, 0, 0, 0, 0, "t8_exec_reset");
    ex(4, 4'b0000, 0, 1, 0, 0, "t8_after_reset");
    ex(5, 4'b0000, 0, 1, 0, 0, "t8_no_retire");
    step(); instr_valid = 0;
    step();
    step(); reset = 0;
    step(); reset = 1;
    step(); step();

    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
